if_id_queue: RTL

Decoupling instruction queue between the fetch stage and the decode stage. Captures each fetched {pc, inst} pair into a small FIFO. Presents the oldest entry to decode with a valid/ready handshake. Drives the fetch-stage PC stall when full, and discards all contents on a pipeline flush (branch/exception redirect).

---
 rtl/if_id_queue_if.sv | 50 +++++
 rtl/if_id_queue.sv | 120 ++++++++++++
 2 files changed

// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue_if
//  Description : Fetch/decode handshake bundle for the IF/ID instruction
//                queue. The fetch side and decode side both sit on the
//                master modport; the queue itself uses the slave modport.
//                With IFQ_PREDECODE_EN defined the bundle carries id_is_cf.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_id_queue_if #(
    parameter int DEPTH = 2
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    // Fetch side
    logic               if_valid;
    logic [31:0]        if_inst;
    logic [31:0]        if_pc;
    logic               pc_stall;
    logic               flush_i;

    // Decode side
    logic               id_valid;
    logic               id_ready;
    logic [31:0]        id_inst;
    logic [31:0]        id_pc;
    logic [c_CNT_W-1:0] ifq_count;
`ifdef IFQ_PREDECODE_EN
    logic               id_is_cf;
`endif

    // Pipeline view: drives fetch data and decode-ready, observes the queue
    modport master (
        output if_valid, if_inst, if_pc, flush_i, id_ready,
        input  pc_stall, id_valid, id_inst, id_pc, ifq_count
`ifdef IFQ_PREDECODE_EN
        , input id_is_cf
`endif
    );

    // Queue view
    modport slave (
        input  if_valid, if_inst, if_pc, flush_i, id_ready,
        output pc_stall, id_valid, id_inst, id_pc, ifq_count
`ifdef IFQ_PREDECODE_EN
        , output id_is_cf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue
//  Description : Decoupling FIFO between fetch and decode. Stores {pc, inst}
//                pairs, presents the oldest to decode over valid/ready,
//                stalls fetch when full and discards everything on flush.
//                Optional macro IFQ_PREDECODE_EN adds a per-entry
//                control-flow flag (branch/jal/jalr) captured at push time.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,      // asynchronous, active low
    if_id_queue_if.slave bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
`ifdef IFQ_PREDECODE_EN
    localparam int c_ENTRY_W = 65;
    localparam logic [c_ENTRY_W-1:0] c_RESET_ENTRY = {1'b0, 32'h0, NOP_INST};
`else
    localparam int c_ENTRY_W = 64;
    localparam logic [c_ENTRY_W-1:0] c_RESET_ENTRY = {32'h0, NOP_INST};
`endif
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    // Entry layout: {[is_cf,] pc[31:0], inst[31:0]}
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_head;

    // Full/empty decode uses only the registered count: no pop lookahead,
    // so pc_stall never depends combinationally on id_ready.
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // Flush wins over both sides of the handshake
    assign w_push = bus.if_valid && !w_full  && !bus.flush_i;
    assign w_pop  = !w_empty && bus.id_ready && !bus.flush_i;

`ifdef IFQ_PREDECODE_EN
    logic w_is_cf;
    // Control-flow opcodes: branch, jal, jalr
    assign w_is_cf = (bus.if_inst[6:0] == 7'b1100011) ||
                     (bus.if_inst[6:0] == 7'b1101111) ||
                     (bus.if_inst[6:0] == 7'b1100111);
    assign w_wr_entry = {w_is_cf, bus.if_pc, bus.if_inst};
`else
    assign w_wr_entry = {bus.if_pc, bus.if_inst};
`endif

    // Entry storage: cleared on reset, written at the write pointer on push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= c_RESET_ENTRY;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (bus.flush_i) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head presentation comes only from registered state, never from if_*
    assign w_head        = r_mem[r_rd_ptr];
    assign bus.id_valid  = !w_empty;
    assign bus.id_inst   = w_empty ? NOP_INST : w_head[31:0];
    assign bus.id_pc     = w_empty ? 32'h0    : w_head[63:32];
    assign bus.pc_stall  = w_full;
    assign bus.ifq_count = r_count;
`ifdef IFQ_PREDECODE_EN
    assign bus.id_is_cf  = !w_empty && w_head[64];
`endif

endmodule
`default_nettype wire
